// File: rtl/minrv32_mem_pkg.sv
// Shared types and constants for the minrv32 native memory port arbiter.
package minrv32_mem_pkg;

  // Arbiter FSM: idle, or serving requester 0 / requester 1.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  // One native-port request as latched at grant time.
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // All-zero strobes mark a read.
  localparam logic [3:0] MEM_READ_STRB = 4'b0000;

  // Value held on the downstream request bus after reset.
  localparam mem_req_t MEM_REQ_NONE = '{
    instr: 1'b0,
    addr:  32'h0000_0000,
    wdata: 32'h0000_0000,
    wstrb: MEM_READ_STRB
  };

  // Bundle one requester's loose ports into a request record.
  function automatic mem_req_t pack_req(
    input logic        instr,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    mem_req_t r;
    r.instr = instr;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state counter for a granted transaction. expired is raised while the
// count sits on the last allowed cycle (TIMEOUT-1); it never rises when
// TIMEOUT is 0.
module mem_arb_timer
  import minrv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: clear wins over enable; counting is off when TIMEOUT is 0.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (TIMEOUT != 32'd0)) begin
      count_d = count_q + TW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (TIMEOUT == 32'd0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [TW-1:0] LAST_CYCLE = TW'(TIMEOUT - 32'd1);
      assign expired = (count_q == LAST_CYCLE);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one minrv32 native memory port.
// m0 is the core, m1 a secondary master (DMA/debug). The winning request is
// latched and held on mem_* until mem_ready or a wait-state timeout; the
// response is steered back combinationally, adding no latency.
module mem_port_arbiter
  import minrv32_mem_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TW         = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_grant_q;   // 0 = m0 was granted last, 1 = m1
  logic       last_grant_d;
  mem_req_t   req_q;
  mem_req_t   req_d;
  logic       mem_valid_q;
  logic       mem_valid_d;

  logic in_busy;
  logic live_busy;
  logic grant_m0;
  logic rsp_ok;
  logic rsp_tmo;
  logic xfer_done;
  logic tmr_expired;

  // In a tie, m0 wins under fixed priority or when m1 had the last grant.
  always_comb begin
    grant_m0 = 1'b0;
    if (m0_valid) begin
      grant_m0 = !m1_valid || (FIXED_PRIO != 32'd0) || last_grant_q;
    end else begin
      grant_m0 = 1'b0;
    end
  end

  // Completion decode. Responses are suppressed while reset is asserted so an
  // aborted transaction never reports ready or err. mem_ready wins over a
  // coincident timeout.
  always_comb begin
    in_busy   = (state_q == BUSY0) || (state_q == BUSY1);
    live_busy = in_busy && resetn && mem_valid_q;
    rsp_ok    = live_busy && mem_ready;
    rsp_tmo   = live_busy && !mem_ready && tmr_expired;
    xfer_done = rsp_ok || rsp_tmo;
  end

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (!in_busy),
    .en      (in_busy && !mem_ready),
    .expired (tmr_expired)
  );

  // Arbitration and transaction tracking.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    mem_valid_d  = mem_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_m0) begin
          state_d      = BUSY0;
          last_grant_d = 1'b0;
          req_d        = pack_req(m0_instr, m0_addr, m0_wdata, m0_wstrb);
          mem_valid_d  = 1'b1;
        end else if (m1_valid) begin
          state_d      = BUSY1;
          last_grant_d = 1'b1;
          req_d        = pack_req(m1_instr, m1_addr, m1_wdata, m1_wstrb);
          mem_valid_d  = 1'b1;
        end else begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end
      end
      BUSY0, BUSY1: begin
        if (xfer_done) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end else begin
          state_d     = state_q;
          mem_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State, grant history and the latched downstream request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      req_q        <= MEM_REQ_NONE;
      mem_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      mem_valid_q  <= mem_valid_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_instr = req_q.instr;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

  // Steer the response to the granted requester only; timeouts return zero data.
  always_comb begin
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = 32'h0000_0000;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = 32'h0000_0000;
    if (state_q == BUSY0) begin
      m0_ready = xfer_done;
      m0_err   = rsp_tmo;
      m0_rdata = rsp_ok ? mem_rdata : 32'h0000_0000;
    end else if (state_q == BUSY1) begin
      m1_ready = xfer_done;
      m1_err   = rsp_tmo;
      m1_rdata = rsp_ok ? mem_rdata : 32'h0000_0000;
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter sharing one native minrv32 memory port (valid/ready, addr/wdata/wstrb/rdata, instr flag) between the core (m0) and a secondary master such as DMA or debug (m1).
- Latches the winning request and drives it downstream until mem_ready.
- Returns the response to the winner with zero added latency.
- Aborts with an error after a configurable wait-state timeout.
- Sits between minrv32 and the memory/formal memory model.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between m0 and m1; 1 = m0 always wins a tie.
- TIMEOUT, 255: maximum cycles a granted transaction waits for mem_ready. 0 disables the timeout.
- TW, 8: width of the timeout counter. Must satisfy TIMEOUT < 2**TW.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m0_valid  in  1  core request
- m0_instr  in  1  core request is an instruction fetch
- m0_addr  in  32  core address
- m0_wdata  in  32  core write data
- m0_wstrb  in  4  core byte strobes (0 = read)
- m0_ready  out  1  core transaction complete
- m0_err  out  1  core transaction timed out (valid with m0_ready)
- m0_rdata  out  32  core read data
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_err, m1_rdata: same widths and meanings for requester 1
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream fetch flag
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. On a reset edge:
  - state <= IDLE; last_grant <= 1, so m0 wins the first tie.
  - mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb <= 0; timer <= 0.
  - All mN_ready, mN_err and mN_rdata read 0 while in IDLE.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - Only m0_valid -> BUSY0. Only m1_valid -> BUSY1.
  - Both valid:
    - FIXED_PRIO=1 -> BUSY0.
    - FIXED_PRIO=0 -> grant the requester that is not last_grant.
  - On grant, register the winner's instr/addr/wdata/wstrb into the mem_* outputs, set mem_valid <= 1, timer <= 0, last_grant <= winner.
  - Arbitration latency: one cycle from mN_valid to mem_valid.
- BUSYn:
  - mem_* outputs are held stable. Later changes on the requester inputs are ignored.
  - mem_ready=1: mn_ready=1 combinationally in the same cycle, mn_rdata=mem_rdata, mn_err=0. Next edge: mem_valid <= 0, state <= IDLE.
  - mem_ready=0 and TIMEOUT!=0: timer increments.
  - Timeout when timer == TIMEOUT-1 and mem_ready=0:
    - mn_ready=1, mn_err=1, mn_rdata=0 that cycle.
    - Next edge: mem_valid <= 0, state <= IDLE.
    - mem_ready and the timeout in the same cycle: mem_ready wins (normal completion, err=0).
  - Non-granted mN_ready, mN_err and mN_rdata are 0 at all times.
- Back-to-back: a requester holding valid after its ready pulse is treated as a new request. It is re-arbitrated in IDLE on the following cycle.
  - Minimum occupancy is 2 cycles per transaction (IDLE + BUSY with immediate ready).
  - Under round-robin, with both requesting continuously, grants alternate 0,1,0,1.
- mem_ready sampled while mem_valid=0 (IDLE, or a late response after a timeout) is ignored.
- Reset mid-transaction: IDLE and mem_valid=0 on the next edge. No ready or err is issued for the aborted transaction.
- Invariant (for formal): mem_valid and mem_* remain stable from grant until mem_ready or timeout.

Decomposition:
- Package minrv32_mem_pkg:
  - arb_state_t enum {IDLE, BUSY0, BUSY1}.
  - mem_req_t struct {instr, addr[31:0], wdata[31:0], wstrb[3:0]}.
  - Constant MEM_READ_STRB = 4'b0000.
- Sub-module mem_arb_timer: TW-bit counter with clear, enable, and an expired flag compared against TIMEOUT. Its expired output is tied 0 when TIMEOUT=0.

Test Plan:
1. m0 read, addr 0x100, mem_ready after 2 wait cycles, rdata 0xDEADBEEF -> mem_valid rises 1 cycle after m0_valid, m0_ready pulses 1 cycle with m0_rdata=0xDEADBEEF, m1_ready stays 0.
2. FIXED_PRIO=0, m0 and m1 request together continuously, zero wait states -> grant order 0,1,0,1, each completion 2 cycles apart. With FIXED_PRIO=1 -> 0,0,0.
3. m1 write, addr 0x2000, wdata 0x12345678, wstrb 0x3, m1_addr changed to 0xFFFF mid-wait -> mem_addr stays 0x2000 with wstrb 0x3 until mem_ready.
4. TIMEOUT=4, m0 read, mem_ready never asserted -> m0_ready=1, m0_err=1, m0_rdata=0 in the 4th BUSY cycle; mem_valid low next cycle. A mem_ready pulse 3 cycles later produces no mN_ready.
5. mem_ready asserted exactly in the timeout cycle -> m0_err=0, normal completion.
6. resetn low during BUSY1 -> mem_valid=0 next edge, no m1_ready. After release, a simultaneous m0/m1 request grants m0 first.
